// File: rtl/puf_pkg.sv
// Shared types and default sizing for the ring-oscillator PUF response collector.
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_RACE    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   localparam int DEF_RESP_BITS      = 16;
   localparam int DEF_SEL_W          = 4;
   localparam int DEF_SETTLE_CYCLES  = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for one asynchronous arbiter signal; synchronous clear to 0.
module puf_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Metastability stage followed by the stable output stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/puf_response_collector.sv
// Sequences RESP_BITS RO-pair races and assembles the arbiter winners into a response.
// Optional race watchdog enabled by defining PUF_RACE_TIMEOUT_EN.
module puf_response_collector
   import puf_pkg::*;
#(
   parameter int RESP_BITS      = DEF_RESP_BITS,
   parameter int SEL_W          = DEF_SEL_W,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [SEL_W-1:0]     i_challenge,
   input  logic                 i_done,
   input  logic                 i_winner,
   output logic [SEL_W-1:0]     o_race_sel,
   output logic                 o_race_rst,
   output logic                 o_race_en,
   output logic [RESP_BITS-1:0] o_response,
   output logic                 o_valid,
   output logic                 o_busy,
   output logic                 o_timeout_err
);

   localparam int IDX_W = cnt_width(RESP_BITS);
   localparam int SET_W = cnt_width(SETTLE_CYCLES);

   state_t                r_state;
   state_t                w_next_state;
   logic [SEL_W-1:0]      r_base;
   logic [IDX_W-1:0]      r_idx;
   logic [SET_W-1:0]      r_settle;
   logic [RESP_BITS-1:0]  r_response;
   logic                  w_sync_rst;
   logic                  w_done_sync;
   logic                  w_winner_sync;
   logic                  w_timeout;
   logic                  w_last_bit;
   logic                  w_settled;

   // Synchronizers are flushed outside RACE so a stale done never shortens the next race.
   assign w_sync_rst = i_rst | (r_state != ST_RACE);
   assign w_last_bit = (r_idx == IDX_W'(RESP_BITS - 1));
   assign w_settled  = (r_settle == SET_W'(SETTLE_CYCLES - 1));

   puf_sync2 u_sync_done (
      .i_clk (i_clk),
      .i_rst (w_sync_rst),
      .i_d   (i_done),
      .o_q   (w_done_sync)
   );

   puf_sync2 u_sync_winner (
      .i_clk (i_clk),
      .i_rst (w_sync_rst),
      .i_d   (i_winner),
      .o_q   (w_winner_sync)
   );

`ifdef PUF_RACE_TIMEOUT_EN
   localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout_err;

   // Done has priority over an expiring watchdog in the same cycle.
   assign w_timeout = (r_state == ST_RACE) && !w_done_sync &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Race watchdog counter and sticky error flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == ST_RACE) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end else begin
            r_to_cnt <= '0;
         end
         if ((r_state == ST_IDLE) && i_start) begin
            r_timeout_err <= 1'b0;
         end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign o_timeout_err = r_timeout_err;
`else
   assign w_timeout     = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    if (i_start) w_next_state = ST_CLEAR;
                     else         w_next_state = ST_IDLE;
         ST_CLEAR:   if (w_settled) w_next_state = ST_RACE;
                     else           w_next_state = ST_CLEAR;
         ST_RACE:    if (w_done_sync || w_timeout) w_next_state = ST_CAPTURE;
                     else                          w_next_state = ST_RACE;
         ST_CAPTURE: if (w_last_bit) w_next_state = ST_FINISH;
                     else            w_next_state = ST_CLEAR;
         ST_FINISH:  w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // Datapath: challenge base, race index, settle counter and response bits.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_base     <= '0;
         r_idx      <= '0;
         r_settle   <= '0;
         r_response <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_base     <= i_challenge;
                  r_idx      <= '0;
                  r_settle   <= '0;
                  r_response <= '0;
               end
            end
            ST_CLEAR: r_settle <= r_settle + SET_W'(1);
            ST_RACE: begin
               if (w_done_sync) begin
                  r_response[r_idx] <= w_winner_sync;
               end else if (w_timeout) begin
                  r_response[r_idx] <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               r_settle <= '0;
               if (!w_last_bit) begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from the state register only.
   always_comb begin
      o_race_rst = 1'b1;
      o_race_en  = 1'b0;
      o_valid    = 1'b0;
      o_busy     = 1'b1;
      case (r_state)
         ST_IDLE:   o_busy = 1'b0;
         ST_RACE: begin
            o_race_rst = 1'b0;
            o_race_en  = 1'b1;
         end
         ST_FINISH: o_valid = 1'b1;
         ST_CLEAR, ST_CAPTURE: ;
         default:   o_busy = 1'b0;
      endcase
   end

   assign o_race_sel = r_base + SEL_W'(r_idx);
   assign o_response = r_response;

endmodule
